// File: rtl/axis_uart_word_rx.sv
// axis_uart_word_rx: 8N1 UART receiver packing N_BYTES bytes per AXI-Stream word via an FWFT FIFO
//   aclk/aresetn          clock, async active-low reset
//   UART_RX               serial line (idles high)
//   M_AXIS_TDATA/TVALID/TREADY  output stream, byte 0 in [7:0]
//   FRAME_ERR/OVERFLOW/TIMEOUT  one-cycle status pulses
module axis_uart_word_rx #(
  parameter int    UART_SPEED    = 115200,
  parameter int    FREQ_HZ       = 100000000,
  parameter int    N_BYTES       = 32,
  parameter int    QUEUE_DEPTH   = 32,
  parameter string QUEUE_MEMTYPE = "auto",
  parameter int    TIMEOUT_BITS  = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 UART_RX,
  output logic [N_BYTES*8-1:0] M_AXIS_TDATA,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  output logic                 FRAME_ERR,
  output logic                 OVERFLOW,
  output logic                 TIMEOUT
);
  localparam int BP   = FREQ_HZ / UART_SPEED;
  localparam int HALF = BP / 2;
  localparam int CW   = $clog2(BP);
  localparam int AW   = $clog2(QUEUE_DEPTH);
  localparam int KW   = N_BYTES > 1 ? $clog2(N_BYTES) : 1;
  localparam int TW   = TIMEOUT_BITS > 0 ? $clog2(TIMEOUT_BITS + 1) : 1;
  localparam int W    = N_BYTES * 8;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BP_M1   = CW'(BP - 1);
  localparam logic [KW-1:0] K_LAST  = KW'(N_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_BITS - 1);
  if (FREQ_HZ < 4 * UART_SPEED) begin : g_bad_freq
    $error("FREQ_HZ must be at least 4*UART_SPEED");
  end
  if (N_BYTES < 1 || QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_size
    $error("N_BYTES must be >= 1 and QUEUE_DEPTH a power of two >= 2");
  end
  if (QUEUE_MEMTYPE != "auto" && QUEUE_MEMTYPE != "distributed" && QUEUE_MEMTYPE != "block") begin : g_bad_mem
    $error("QUEUE_MEMTYPE must be auto, distributed or block");
  end
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
  state_t        r_st, w_nxt;
  logic          r_rx_m, r_rx_s;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_byte_vld, r_fe, r_to, r_ovf;
  logic          w_tick, w_good, w_ferr;
  logic [KW-1:0] r_k;
  logic [W-1:0]  r_word, w_word;
  logic [CW-1:0] r_icyc;
  logic [TW-1:0] r_ibits;
  logic          w_idle, w_btick, w_to;
  logic [AW:0]   r_wp, r_rp;
  logic [W-1:0]  r_mem [QUEUE_DEPTH];
  logic          w_full, w_pop, w_push, w_wr;
  always_comb begin
    w_tick = r_cnt == '0;
    w_nxt  = r_st;
    w_cnt  = r_cnt - 1'b1;
    w_good = 1'b0;
    w_ferr = 1'b0;
    case (r_st)
      S_IDLE:  if (!r_rx_s) begin w_nxt = S_START; w_cnt = HALF_M1; end
      S_START: if (w_tick) begin w_nxt = r_rx_s ? S_IDLE : S_DATA; w_cnt = BP_M1; end
      S_DATA:  if (w_tick) begin w_nxt = r_bit == 3'd7 ? S_STOP : S_DATA; w_cnt = BP_M1; end
      S_STOP:  if (w_tick) begin w_good = r_rx_s; w_ferr = !r_rx_s; w_nxt = r_rx_s ? S_IDLE : S_BREAK; end
      S_BREAK: if (r_rx_s) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_rx_m     <= 1'b1;
      r_rx_s     <= 1'b1;
      r_st       <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_byte_vld <= 1'b0;
      r_fe       <= 1'b0;
    end else begin
      r_rx_m     <= UART_RX;
      r_rx_s     <= r_rx_m;
      r_st       <= w_nxt;
      r_cnt      <= w_cnt;
      r_byte_vld <= w_good;
      r_fe       <= w_ferr;
      if (r_st == S_DATA && w_tick) begin
        r_shift <= {r_rx_s, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
    end
  // r_shift stays put while the FSM is idle, so it is still the received byte when r_byte_vld is seen
  always_comb begin
    w_word = r_word;
    w_word[r_k*8 +: 8] = r_shift;
  end
  // idle bit-time counter runs only while a partial word waits and the line is between bytes
  assign w_idle  = TIMEOUT_BITS != 0 && r_st == S_IDLE && r_k != '0;
  assign w_btick = r_icyc == BP_M1;
  assign w_to    = w_idle && w_btick && r_ibits == TO_LAST;
  assign w_pop   = M_AXIS_TVALID && M_AXIS_TREADY;
  assign w_full  = r_wp[AW] != r_rp[AW] && r_wp[AW-1:0] == r_rp[AW-1:0];
  assign w_push  = r_byte_vld && r_k == K_LAST;
  assign w_wr    = w_push && (!w_full || w_pop);
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_k     <= '0;
      r_word  <= '0;
      r_icyc  <= '0;
      r_ibits <= '0;
      r_to    <= 1'b0;
      r_ovf   <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
    end else begin
      r_to  <= w_to;
      r_ovf <= w_push && !w_wr;
      if (w_ferr || w_to) r_k <= '0;
      else if (r_byte_vld) begin
        r_word <= w_word;
        r_k    <= r_k == K_LAST ? '0 : r_k + 1'b1;
      end
      if (!w_idle || w_to) begin
        r_icyc  <= '0;
        r_ibits <= '0;
      end else if (w_btick) begin
        r_icyc  <= '0;
        r_ibits <= r_ibits + 1'b1;
      end else r_icyc <= r_icyc + 1'b1;
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  always_ff @(posedge aclk)
    if (w_wr) r_mem[r_wp[AW-1:0]] <= w_word;
  assign M_AXIS_TVALID = r_wp != r_rp;
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? r_mem[r_rp[AW-1:0]] : '0;
  assign FRAME_ERR     = r_fe;
  assign OVERFLOW      = r_ovf;
  assign TIMEOUT       = r_to;
endmodule

// File: tb/tb_axis_uart_word_rx.sv
// tb_axis_uart_word_rx: directed self-checking bench for axis_uart_word_rx (BIT_PERIOD=10, 4-byte words)
module tb_axis_uart_word_rx;
  localparam int BP = 10;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        UART_RX = 1'b1;
  logic        tready = 1'b0;
  logic [31:0] tdata;
  logic        tvalid, fe, ov, to;
  axis_uart_word_rx #(
    .UART_SPEED(10000000), .FREQ_HZ(100000000), .N_BYTES(4),
    .QUEUE_DEPTH(4), .QUEUE_MEMTYPE("auto"), .TIMEOUT_BITS(32)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .UART_RX(UART_RX),
    .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
    .FRAME_ERR(fe), .OVERFLOW(ov), .TIMEOUT(to)
  );
  always #5 aclk = ~aclk;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  int n_fe, n_ov, n_to, n_unstable, to_cyc, t_start;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] q_data[$];
  int          q_cyc[$];
  always @(negedge aclk)
    if (!aresetn) prev_stall = 1'b0;
    else begin
      if (tvalid && tready) begin
        q_data.push_back(tdata);
        q_cyc.push_back(cyc);
      end
      n_fe += int'(fe);
      n_ov += int'(ov);
      if (to) begin
        n_to++;
        to_cyc = cyc;
      end
      if (prev_stall && (!tvalid || tdata != prev_data)) n_unstable++;
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
    end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask
  task automatic clear_mon();
    q_data.delete();
    q_cyc.delete();
    n_fe = 0;
    n_ov = 0;
    n_to = 0;
    n_unstable = 0;
    to_cyc = -1;
  endtask
  task automatic send_byte(input logic [7:0] b, input int stop_low = 0);
    UART_RX = 1'b0;
    t_start = cyc;
    tick(BP);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      tick(BP);
    end
    if (stop_low > 0) begin
      UART_RX = 1'b0;
      tick(stop_low * BP);
    end
    UART_RX = 1'b1;
    tick(BP);
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask
  function automatic logic [31:0] beat(input int i);
    return q_data.size() > i ? q_data[i] : 32'hxxxxxxxx;
  endfunction
  int t4, tbb;
  logic [7:0] b2;
  initial begin
    clear_mon();
    tick(3);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_frame_err", fe, 0);
    check("rst_overflow", ov, 0);
    check("rst_timeout", to, 0);
    aresetn = 1'b1;
    tick(5);
    tready = 1'b1;
    // 1: basic word and latency
    clear_mon();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    t4 = t_start;
    tick(20);
    check("t1_beats", q_data.size(), 1);
    check("t1_data", beat(0), 32'h44332211);
    check("t1_latency", q_cyc.size() > 0 ? q_cyc[0] - t4 : -1, 99);
    check("t1_errs", n_fe + n_ov + n_to, 0);
    // 2: glitch shorter than half a bit is ignored
    clear_mon();
    UART_RX = 1'b0;
    tick(3);
    UART_RX = 1'b1;
    tick(20);
    send_word(32'hA5A5A5A5);
    tick(20);
    check("t2_beats", q_data.size(), 1);
    check("t2_data", beat(0), 32'hA5A5A5A5);
    check("t2_errs", n_fe + n_ov + n_to, 0);
    // 3: framing error discards the partial word
    clear_mon();
    send_byte(8'h01);
    send_byte(8'h02, 2);
    send_word(32'h40302010);
    tick(20);
    check("t3_frame_err", n_fe, 1);
    check("t3_beats", q_data.size(), 1);
    check("t3_data", beat(0), 32'h40302010);
    check("t3_timeout", n_to, 0);
    // 4: partial word timeout
    clear_mon();
    send_byte(8'hAA);
    send_byte(8'hBB);
    tbb = t_start;
    tick(40 * BP);
    send_word(32'hCCCCCCCC);
    tick(20);
    check("t4_timeout", n_to, 1);
    check("t4_to_time", to_cyc >= tbb + 407 && to_cyc <= tbb + 429, 1);
    check("t4_beats", q_data.size(), 1);
    check("t4_data", beat(0), 32'hCCCCCCCC);
    check("t4_frame_err", n_fe, 0);
    // 5: overflow with stalled consumer, then drain
    clear_mon();
    tready = 1'b0;
    for (int w = 1; w <= 5; w++) send_word(w);
    tick(10);
    check("t5_overflow", n_ov, 1);
    check("t5_no_beats", q_data.size(), 0);
    check("t5_tvalid", tvalid, 1);
    check("t5_head", tdata, 1);
    tready = 1'b1;
    tick(10);
    check("t5_beats", q_data.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t5_data%0d", i), beat(i), i + 1);
    check("t5_back_to_back", q_cyc.size() == 4 ? q_cyc[3] - q_cyc[0] : -1, 3);
    check("t5_stable", n_unstable, 0);
    // 6: reset mid-byte clears everything, including a pending word
    clear_mon();
    tready = 1'b0;
    send_word(32'h0BADF00D);
    tick(5);
    check("t6_pre_tvalid", tvalid, 1);
    send_byte(8'h55);
    b2 = 8'h3C;
    UART_RX = 1'b0;
    tick(BP);
    for (int i = 0; i < 4; i++) begin
      UART_RX = b2[i];
      tick(BP);
    end
    UART_RX = b2[4];
    tick(5);
    aresetn = 1'b0;
    tick(1);
    check("t6_rst_tvalid", tvalid, 0);
    check("t6_rst_tdata", tdata, 0);
    check("t6_rst_pulses", {fe, ov, to}, 0);
    tick(5);
    UART_RX = 1'b1;
    tick(5);
    aresetn = 1'b1;
    tick(30);
    check("t6_quiet", tvalid, 0);
    clear_mon();
    tready = 1'b1;
    send_word(32'hEFBEADDE);
    tick(20);
    check("t6_beats", q_data.size(), 1);
    check("t6_data", beat(0), 32'hEFBEADDE);
    check("t6_errs", n_fe + n_ov + n_to, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_uart_word_rx.md
# axis_uart_word_rx

Standalone UART receiver that deserializes 8N1 bytes from a UART_RX line and packs N_BYTES consecutive bytes into one AXI-Stream word. It is the host-to-fabric end of the UART bridge link and sits between the board UART pin and an AXIS consumer. It adds framing-error detection, partial-word timeout and overflow reporting.

## Interface
- UART_SPEED, 115200: line baud rate in bit/s.
- FREQ_HZ, 100000000: aclk frequency in Hz; must be ≥ 4*UART_SPEED, otherwise elaboration fails with $error.
- N_BYTES, 32: bytes per output word, ≥ 1.
- QUEUE_DEPTH, 32: output FIFO depth in words; power of two, ≥ 2.
- QUEUE_MEMTYPE, "auto": FIFO RAM style hint: "auto", "distributed" or "block".
- TIMEOUT_BITS, 32: idle bit-times after which a partial word is discarded; 0 disables the timeout.
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- UART_RX  in  1  asynchronous serial line; idles high.
- M_AXIS_TDATA  out  N_BYTES*8  assembled word; byte 0 (first received) in [7:0].
- M_AXIS_TVALID  out  1  word valid.
- M_AXIS_TREADY  in  1  consumer ready.
- FRAME_ERR  out  1  one-cycle pulse when a stop bit samples 0.
- OVERFLOW  out  1  one-cycle pulse when a completed word is dropped because the FIFO is full.
- TIMEOUT  out  1  one-cycle pulse when a partial word is discarded.

## Operation
- BIT_PERIOD = FREQ_HZ/UART_SPEED, using truncating integer division. HALF = BIT_PERIOD/2. The baud counter is $clog2(BIT_PERIOD) bits wide.
- UART_RX passes through a 2-flop synchronizer whose flops reset to 1. All decisions use the synchronized value rx_s.
- Byte FSM:
  - IDLE: on rx_s == 0, load the counter and go to START.
  - START: after HALF cycles, sample rx_s. If 1, the start is false: go to IDLE with no error. If 0, go to DATA with bit index 0.
  - DATA: sample every BIT_PERIOD cycles, LSB first. After bit 7, go to STOP.
  - STOP: after BIT_PERIOD cycles, sample rx_s.
    - If 1: deliver the byte to the assembler and go to IDLE.
    - If 0: pulse FRAME_ERR, discard the byte and the whole partial word (byte index reset to 0), then go to BREAK.
  - BREAK: wait for rx_s == 1, then go to IDLE. This prevents re-triggering on a held-low line.
- Assembler:
  - Byte index k counts 0..N_BYTES-1. Each byte is written to shift_word[8k+7:8k].
  - When byte N_BYTES-1 arrives, the word is pushed to the FIFO and k wraps to 0.
- Timeout:
  - While k != 0 and the FSM is in IDLE, an idle counter counts bit periods. It clears whenever a start bit is accepted.
  - When it reaches TIMEOUT_BITS: pulse TIMEOUT, clear k, discard the partial word.
- FIFO: first-word-fall-through, QUEUE_DEPTH words.
  - A push is accepted if the FIFO is not full, or if a pop (TVALID && TREADY) happens in the same cycle.
  - Otherwise the completed word is dropped and OVERFLOW pulses.
  - Read and write pointers are $clog2(QUEUE_DEPTH)+1 bits and wrap naturally. Full means the MSBs differ and the remaining bits are equal.
- AXIS rules:
  - TDATA is stable while TVALID && !TREADY.
  - TVALID is never withdrawn without a handshake.
  - TREADY has no combinational path to TVALID.

## Timing
- Reset values: M_AXIS_TVALID=0, M_AXIS_TDATA=0, FRAME_ERR=0, OVERFLOW=0, TIMEOUT=0, FSM=IDLE, k=0, FIFO empty.
- Reset mid-byte or mid-word discards all partial data. There is no output activity until a fresh start bit follows reset release.
- Start detection lags a UART_RX edge by 2 cycles (synchronizer).
- Sample instants relative to the first cycle rx_s == 0:
  - start bit at HALF;
  - data bit i at HALF + (i+1)*BIT_PERIOD;
  - stop bit at HALF + 9*BIT_PERIOD.
- Latency from the last byte's stop-bit sample (cycle S):
  - FIFO write at S+1.
  - With the FIFO empty, M_AXIS_TVALID=1 at S+2.
- FIFO throughput is one word per cycle.
- A new start bit is accepted the cycle after the STOP sample with rx_s == 1. No extra idle time is required between bytes.
- FRAME_ERR, OVERFLOW and TIMEOUT are each exactly one cycle wide. They are registered and asserted in the cycle after the triggering sample.

## Test plan
Use FREQ_HZ=100e6, UART_SPEED=10e6 (BIT_PERIOD=10), N_BYTES=4, QUEUE_DEPTH=4, TIMEOUT_BITS=32.

1. Send bytes 0x11, 0x22, 0x33, 0x44 back-to-back with TREADY=1 -> exactly one beat with TDATA=0x44332211, arriving 2 cycles after the 4th stop sample. FRAME_ERR, OVERFLOW and TIMEOUT stay 0.
2. Pulse the line low for 3 cycles (glitch), then send 0xA5 ×4 -> no error pulses; one word 0xA5A5A5A5.
3. Send 0x01, then 0x02 with its stop bit driven 0 for 2 bit-times, then 0x10, 0x20, 0x30, 0x40 -> FRAME_ERR pulses once; the only output word is 0x40302010.
4. Send 0xAA, 0xBB, then idle for 40 bit-times, then send 0xCC ×4 -> TIMEOUT pulses once, about 32 bit-times after the 0xBB stop; the only output word is 0xCCCCCCCC.
5. Hold TREADY=0 and send 5 words with values 1..5 -> the 5th word is dropped and OVERFLOW pulses once. Then raise TREADY -> words 1, 2, 3, 4 come out in order with TDATA stable while stalled.
6. Assert aresetn=0 during data bit 4 of the 2nd byte, then release and send 4 new bytes -> all outputs are 0 during reset; exactly one word, made of the 4 new bytes only.
